// File: rtl/ac97_cmd_seq.sv
// AC-link codec register-access sequencer: one read/write per request,
// one outbound command frame, optional reply wait with frame timeout.
module ac97_cmd_seq #(
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic        ac97_bitclk,
  input  logic        ac97_reset,
  input  logic        frame_start,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_read,
  input  logic [6:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic [19:0] ac97_out_slot1,
  output logic        ac97_out_slot1_valid,
  output logic [19:0] ac97_out_slot2,
  output logic        ac97_out_slot2_valid,
  input  logic        in_frame_done,
  input  logic        in_slot1_valid,
  input  logic [19:0] in_slot1,
  input  logic        in_slot2_valid,
  input  logic [19:0] in_slot2,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [15:0] rsp_data
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SEND,
    WAIT_RSP
  } state_t;

  state_t      state, state_nxt;
  logic        lat_read, lat_read_nxt;
  logic [6:0]  lat_addr, lat_addr_nxt;
  logic [15:0] lat_wdata, lat_wdata_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [3:0]  cnt_inc;
  logic [19:0] slot1_nxt, slot2_nxt;
  logic        slot1_v_nxt, slot2_v_nxt;
  logic        rsp_valid_nxt, rsp_err_nxt;
  logic [15:0] rsp_data_nxt;
  logic        hit;
  logic        unused_bits;

  // Only the address field of the status slot and the data field of
  // the status data slot carry meaning for a read reply.
  assign unused_bits = ^{in_slot1[19], in_slot1[11:0], in_slot2[3:0]};

  assign cmd_ready = (state == IDLE);
  assign cnt_inc   = cnt + 4'd1;
  assign hit = in_frame_done && in_slot1_valid && in_slot2_valid
            && (in_slot1[18:12] == lat_addr);

  always_ff @(posedge ac97_bitclk) begin
    if (ac97_reset) begin
      state                <= IDLE;
      lat_read             <= 1'b0;
      lat_addr             <= '0;
      lat_wdata            <= '0;
      cnt                  <= '0;
      ac97_out_slot1       <= '0;
      ac97_out_slot2       <= '0;
      ac97_out_slot1_valid <= 1'b0;
      ac97_out_slot2_valid <= 1'b0;
      rsp_valid            <= 1'b0;
      rsp_err              <= 1'b0;
      rsp_data             <= '0;
    end else begin
      state                <= state_nxt;
      lat_read             <= lat_read_nxt;
      lat_addr             <= lat_addr_nxt;
      lat_wdata            <= lat_wdata_nxt;
      cnt                  <= cnt_nxt;
      ac97_out_slot1       <= slot1_nxt;
      ac97_out_slot2       <= slot2_nxt;
      ac97_out_slot1_valid <= slot1_v_nxt;
      ac97_out_slot2_valid <= slot2_v_nxt;
      rsp_valid            <= rsp_valid_nxt;
      rsp_err              <= rsp_err_nxt;
      rsp_data             <= rsp_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    lat_read_nxt  = lat_read;
    lat_addr_nxt  = lat_addr;
    lat_wdata_nxt = lat_wdata;
    cnt_nxt       = cnt;
    slot1_nxt     = ac97_out_slot1;
    slot2_nxt     = ac97_out_slot2;
    slot1_v_nxt   = ac97_out_slot1_valid;
    slot2_v_nxt   = ac97_out_slot2_valid;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = rsp_err;
    rsp_data_nxt  = rsp_data;

    unique case (state)
      IDLE: begin
        // frame_start here is deliberately ignored: the command
        // always waits for the next full frame boundary.
        if (cmd_valid) begin
          lat_read_nxt  = cmd_read;
          lat_addr_nxt  = cmd_addr;
          lat_wdata_nxt = cmd_wdata;
          state_nxt     = ARM;
        end
      end
      ARM: begin
        if (frame_start) begin
          slot1_nxt   = {lat_read, lat_addr, 12'h000};
          slot2_nxt   = lat_read ? 20'h0 : {lat_wdata, 4'h0};
          slot1_v_nxt = 1'b1;
          slot2_v_nxt = !lat_read;
          state_nxt   = SEND;
        end
      end
      SEND: begin
        if (frame_start) begin
          slot1_nxt   = '0;
          slot2_nxt   = '0;
          slot1_v_nxt = 1'b0;
          slot2_v_nxt = 1'b0;
          if (lat_read) begin
            cnt_nxt   = '0;
            state_nxt = WAIT_RSP;
          end else begin
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b0;
            rsp_data_nxt  = '0;
            state_nxt     = IDLE;
          end
        end
      end
      WAIT_RSP: begin
        // A matching reply takes priority over the timeout boundary.
        if (hit) begin
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b0;
          rsp_data_nxt  = in_slot2[19:4];
          state_nxt     = IDLE;
        end else if (frame_start) begin
          if (cnt_inc == 4'(TIMEOUT_FRAMES)) begin
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            rsp_data_nxt  = '0;
            state_nxt     = IDLE;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ac97_cmd_seq.sv
// Bench for ac97_cmd_seq: timestamp-based model of frame timing,
// directed scenarios with literal pins, then randomized traffic.
module tb_ac97_cmd_seq;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        cmd_valid, cmd_ready, cmd_read;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic [19:0] o_s1, o_s2;
  logic        o_s1v, o_s2v;
  logic        ifd, is1v, is2v;
  logic [19:0] is1, is2;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_data;

  ac97_cmd_seq #(.TIMEOUT_FRAMES(TO)) dut (
    .ac97_bitclk(clk),
    .ac97_reset(rst),
    .frame_start(frame_start),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_read(cmd_read),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .ac97_out_slot1(o_s1),
    .ac97_out_slot1_valid(o_s1v),
    .ac97_out_slot2(o_s2),
    .ac97_out_slot2_valid(o_s2v),
    .in_frame_done(ifd),
    .in_slot1_valid(is1v),
    .in_slot1(is1),
    .in_slot2_valid(is2v),
    .in_slot2(is2),
    .rsp_valid(rsp_valid),
    .rsp_err(rsp_err),
    .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  longint m = 0;

  // stimulus for the next rising edge
  logic        d_rst, d_valid, d_read, d_ifd, d_s1v, d_s2v;
  logic [6:0]  d_addr;
  logic [15:0] d_wdata;
  logic [19:0] d_s1, d_s2;

  // model: one outstanding transaction described by timestamps
  bit          act;
  bit          a_rd;
  logic [6:0]  a_addr;
  logic [15:0] a_wd;
  longint      f, rsp_cyc;
  bit          r_err;
  logic [15:0] r_data;
  bit          h_err;
  logic [15:0] h_data;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, m, got, want);
    end
  endtask

  task automatic step();
    bit in_send, e_rv, e_rdy;
    logic [19:0] e_s1, e_s2;
    @(negedge clk);
    in_send = act && m >= f + 1 && m <= f + 256;
    e_rv    = act && m == rsp_cyc;
    e_rdy   = !act || e_rv;
    if (e_rv) begin
      h_err  = r_err;
      h_data = r_data;
    end
    e_s1 = in_send ? {a_rd, a_addr, 12'h000} : 20'h0;
    e_s2 = (in_send && !a_rd) ? {a_wd, 4'h0} : 20'h0;
    chk("cmd_ready", 32'(cmd_ready), 32'(e_rdy));
    chk("slot1", 32'(o_s1), 32'(e_s1));
    chk("slot1_valid", 32'(o_s1v), 32'(in_send));
    chk("slot2", 32'(o_s2), 32'(e_s2));
    chk("slot2_valid", 32'(o_s2v), 32'(in_send && !a_rd));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk("rsp_err", 32'(rsp_err), 32'(h_err));
    chk("rsp_data", 32'(rsp_data), 32'(h_data));
    if (e_rv) act = 0;

    rst         = d_rst;
    frame_start = (m % 256 == 255);
    cmd_valid   = d_valid;
    cmd_read    = d_read;
    cmd_addr    = d_addr;
    cmd_wdata   = d_wdata;
    ifd         = d_ifd;
    is1v        = d_s1v;
    is1         = d_s1;
    is2v        = d_s2v;
    is2         = d_s2;

    if (d_rst) begin
      act    = 0;
      h_err  = 0;
      h_data = '0;
    end else begin
      if (act && a_rd && d_ifd && d_s1v && d_s2v && d_s1[18:12] == a_addr
          && m >= f + 257 && m < rsp_cyc) begin
        rsp_cyc = m + 1;
        r_err   = 0;
        r_data  = d_s2[19:4];
      end
      if (d_valid && !act) begin
        act     = 1;
        a_rd    = d_read;
        a_addr  = d_addr;
        a_wd    = d_wdata;
        f       = m + 256 - ((m + 1) % 256);
        rsp_cyc = d_read ? f + 257 + 256 * TO : f + 257;
        r_err   = d_read;
        r_data  = '0;
      end
    end
    m++;
  endtask

  task automatic drain();
    for (int k = 0; k < 3000 && act; k++) step();
    if (act) begin
      checks++;
      errors++;
      $display("FAIL drain cyc=%0d got=busy want=idle", m);
    end
  endtask

  task automatic to_bit(input int b);
    while (m % 256 != b) step();
  endtask

  task automatic quiet();
    d_valid = 0; d_read = 0; d_addr = '0; d_wdata = '0;
    d_ifd = 0; d_s1v = 0; d_s2v = 0; d_s1 = '0; d_s2 = '0;
  endtask

  longint m0;

  initial begin
    act = 0; h_err = 0; h_data = '0; f = 0; rsp_cyc = 0;
    quiet();
    d_rst = 1;
    rst = 1; frame_start = 0; cmd_valid = 0; cmd_read = 0;
    cmd_addr = '0; cmd_wdata = '0; ifd = 0; is1v = 0; is2v = 0;
    is1 = '0; is2 = '0;
    repeat (4) step();
    d_rst = 0;
    step();
    chk("reset ready", 32'(cmd_ready), 1);
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset slot1_valid", 32'(o_s1v), 0);

    // write at bit 100
    to_bit(100);
    d_valid = 1; d_read = 0; d_addr = 7'h02; d_wdata = 16'h8000;
    step();
    d_valid = 0;
    while (m < f + 1) step();
    chk("wr pre-frame s1v", 32'(o_s1v), 0);
    step();
    chk("wr slot1", 32'(o_s1), 32'h02000);
    chk("wr slot2", 32'(o_s2), 32'h80000);
    chk("wr s2v", 32'(o_s2v), 1);
    chk("wr busy", 32'(cmd_ready), 0);
    repeat (255) step();
    chk("wr last bit s1v", 32'(o_s1v), 1);
    step();
    chk("wr rsp_valid", 32'(rsp_valid), 1);
    chk("wr rsp_data", 32'(rsp_data), 0);
    chk("wr s1v cleared", 32'(o_s1v), 0);

    // read hit with a second request held behind it
    to_bit(10);
    d_valid = 1; d_read = 1; d_addr = 7'h7C;
    step();
    d_read = 0; d_addr = 7'h10; d_wdata = 16'h1234;
    while (m < f + 1) step();
    step();
    chk("rd slot1", 32'(o_s1), 32'hFC000);
    chk("rd s1v", 32'(o_s1v), 1);
    chk("rd s2v", 32'(o_s2v), 0);
    while (m < f + 277) step();
    d_ifd = 1; d_s1v = 1; d_s2v = 1; d_s1 = 20'h7C000; d_s2 = 20'h83840;
    step();
    d_ifd = 0;
    step();
    d_valid = 0;
    chk("rd rsp_valid", 32'(rsp_valid), 1);
    chk("rd rsp_data", 32'(rsp_data), 32'h8384);
    chk("rd rsp_err", 32'(rsp_err), 0);
    step();
    chk("queued accept", 32'(cmd_ready), 0);
    quiet();
    drain();

    // timeout with mismatched replies every frame
    to_bit(200);
    d_valid = 1; d_read = 1; d_addr = 7'h11;
    step();
    d_valid = 0;
    d_s1 = 20'h7E000; d_s1v = 1; d_s2v = 1; d_s2 = 20'h12340;
    while (m < f + 1281) begin
      d_ifd = (m % 256 == 30);
      step();
    end
    chk("to early rsp", 32'(rsp_valid), 0);
    d_ifd = 0;
    step();
    chk("to rsp_valid", 32'(rsp_valid), 1);
    chk("to rsp_err", 32'(rsp_err), 1);
    chk("to rsp_data", 32'(rsp_data), 0);
    quiet();
    drain();

    // reply coincides with the timeout frame_start
    to_bit(5);
    d_valid = 1; d_read = 1; d_addr = 7'h33;
    step();
    d_valid = 0;
    while (m < f + 1280) step();
    d_ifd = 1; d_s1v = 1; d_s2v = 1; d_s1 = 20'h33000; d_s2 = 20'hBEEF0;
    step();
    d_ifd = 0;
    step();
    chk("sim rsp_valid", 32'(rsp_valid), 1);
    chk("sim rsp_err", 32'(rsp_err), 0);
    chk("sim rsp_data", 32'(rsp_data), 32'hBEEF);
    quiet();
    drain();

    // request lands on frame_start
    to_bit(255);
    m0 = m;
    d_valid = 1; d_read = 0; d_addr = 7'h55; d_wdata = 16'hA5A5;
    step();
    d_valid = 0;
    step();
    chk("fs same-cycle s1v", 32'(o_s1v), 0);
    while (m < m0 + 258) step();
    chk("fs next frame s1v", 32'(o_s1v), 1);
    chk("fs next frame slot1", 32'(o_s1), 32'h55000);
    drain();

    // reset at bit 50 of the send frame
    to_bit(0);
    d_valid = 1; d_read = 0; d_addr = 7'h01; d_wdata = 16'h0001;
    step();
    d_valid = 0;
    while (m < f + 51) step();
    d_rst = 1;
    step();
    d_rst = 0;
    step();
    chk("rst s1v", 32'(o_s1v), 0);
    chk("rst s2v", 32'(o_s2v), 0);
    chk("rst ready", 32'(cmd_ready), 1);
    chk("rst rsp_valid", 32'(rsp_valid), 0);
    repeat (600) step();

    // randomized traffic: frequent then rare replies
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 12000; i++) begin
        d_rst   = ($urandom % 5000 == 0);
        d_valid = ($urandom % 16 == 0);
        d_read  = $urandom_range(0, 1);
        d_addr  = 7'($urandom);
        d_wdata = 16'($urandom);
        d_ifd   = ph == 0 ? ($urandom % 100 == 0) : ($urandom % 1500 == 0);
        d_s1v   = ($urandom % 4 != 0);
        d_s2v   = ($urandom % 4 != 0);
        d_s1    = {1'($urandom),
                   ($urandom_range(0, 1) ? a_addr : 7'($urandom)),
                   12'($urandom)};
        d_s2    = 20'($urandom);
        step();
      end
    end
    quiet();
    d_rst = 0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ac97_cmd_seq.md
Name: ac97_cmd_seq

Overview:
- Codec register-access sequencer sitting directly upstream of the AC-link framer.
- Accepts one register read or write request at a time over a valid/ready handshake and drives the framer's outbound slot1/slot2 words and valid bits for exactly one frame.
- For reads, it consumes the deserialized inbound slot1/slot2 and returns the matching 16-bit register value, or a timeout error.

Parameters:
- TIMEOUT_FRAMES, 4: frames to wait for a read reply before erroring (legal range 1..15).

Ports:
- ac97_bitclk  in  1  AC-link bit clock; all logic on its rising edge.
- ac97_reset  in  1  Synchronous, active-high reset.
- frame_start  in  1  One-cycle pulse from the framer on the last bit (bit 255) of each frame.
- cmd_valid  in  1  Request present.
- cmd_ready  out  1  Sequencer can accept a request.
- cmd_read  in  1  1 = register read, 0 = register write.
- cmd_addr  in  7  Codec register address (word address, bits 6:0).
- cmd_wdata  in  16  Write data; ignored for reads.
- ac97_out_slot1  out  20  Command address slot to framer.
- ac97_out_slot1_valid  out  1  Tag bit for slot1.
- ac97_out_slot2  out  20  Command data slot to framer.
- ac97_out_slot2_valid  out  1  Tag bit for slot2.
- in_frame_done  in  1  One-cycle pulse: inbound slots below are valid for one completed frame.
- in_slot1_valid  in  1  Inbound tag bit for slot1.
- in_slot1  in  20  Inbound status address slot.
- in_slot2_valid  in  1  Inbound tag bit for slot2.
- in_slot2  in  20  Inbound status data slot.
- rsp_valid  out  1  One-cycle completion pulse.
- rsp_err  out  1  Qualified by rsp_valid: read timed out.
- rsp_data  out  16  Qualified by rsp_valid: read data; 0 for writes and errors.

Behaviour:
- Reset: state IDLE; cmd_ready=1; slot outputs and slot valids =0; rsp_valid=0, rsp_err=0, rsp_data=0; frame counter=0. Reset mid-transaction abandons the request without a response; slot valids drop on the first post-reset cycle.
- Slot encoding:
  - slot1 = {cmd_read, cmd_addr[6:0], 12'b0}.
  - slot2 = {cmd_wdata, 4'b0} for writes; 20'h0 for reads.
  - Reads assert slot1_valid only. Writes assert slot1_valid and slot2_valid.
- cmd_ready = (state==IDLE). Accept = cmd_valid && cmd_ready. cmd_read, cmd_addr and cmd_wdata are latched on accept.
- States:
  - IDLE: on accept -> ARM. A frame_start in the same cycle is ignored; the command goes out in the following frame.
  - ARM: on frame_start, register slot outputs and valids (visible from bit 0 of the next frame) -> SEND.
  - SEND: outputs held constant for the whole frame. On the next frame_start, clear slot outputs and valids to 0.
    - Write: rsp_valid=1, rsp_err=0, rsp_data=0 next cycle -> IDLE.
    - Read: frame counter=0 -> WAIT_RSP.
  - WAIT_RSP: on in_frame_done with in_slot1_valid && in_slot2_valid && in_slot1[18:12]==latched addr, set rsp_valid=1, rsp_err=0, rsp_data=in_slot2[19:4] -> IDLE.
    - Otherwise each frame_start increments the counter. When the counter reaches TIMEOUT_FRAMES, set rsp_valid=1, rsp_err=1, rsp_data=0 -> IDLE.
    - If in_frame_done with a match and the timeout frame_start occur in the same cycle, the match wins.
- Response timing: rsp_valid is a one-cycle pulse. rsp_data/rsp_err are held until the next response. IDLE is re-entered the same cycle rsp_valid is high, so a new request can be accepted that cycle.
- Inbound pulses outside WAIT_RSP are ignored. A mismatched address or a missing tag bit is ignored and does not reset the counter.
- Latency:
  - Write: accept -> rsp_valid = wait-to-frame_start + 256 bit clocks + 1.
  - Read: additionally the codec reply frame, bounded by TIMEOUT_FRAMES*256.
- Output slot regs change only in the cycle after frame_start (or after reset), never mid-frame.

Test Plan:
- Write: accept addr=7'h02, wdata=16'h8000 at curbit 100 → outputs still 0 through bit 255. From the next frame's bit 0, slot1=20'h02000, slot2=20'h80000, both valids=1 for 256 cycles, then 0 → rsp_valid pulse, err=0, data=0.
- Read hit: read addr=7'h7C. The frame after the send, drive in_frame_done with slot1=20'h7C000, slot2=20'h83840, both valid → rsp_data=16'h8384, err=0. The send frame has slot1=20'hFC000, slot1_valid=1, slot2_valid=0.
- Read timeout: TIMEOUT_FRAMES=4, never reply (or reply with addr 7'h7E) → rsp_valid, err=1, data=0 exactly on the cycle after the 4th frame_start following the send frame.
- Boundary: cmd_valid in the same cycle as frame_start → slots stay 0 that frame and go out in the following frame. cmd_ready=0 from ARM through completion; a second cmd_valid held during that time is accepted on the rsp_valid cycle.
- Simultaneous: a matching in_frame_done on the same cycle as the timeout frame_start → err=0, correct data.
- Reset mid-SEND: assert ac97_reset for 1 cycle at bit 50 → slot valids=0 on the next cycle, no rsp_valid, cmd_ready=1.
